seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 1000: clocks each digit is driven in SHOW; legal range 2..65535.
REQ-002 SHALL have parameter BLANK, default 4: clocks of all-off between digits; legal range 1..255.
REQ-003 SHALL have port clk  input  1  the single clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  scan enable.
REQ-006 SHALL have port wr_en  input  1  digit write request.
REQ-007 SHALL have port wr_addr  input  2  digit index to write (0 = rightmost).
REQ-008 SHALL have port wr_data  input  5  bit4 = decimal point, bits3:0 = hex value.
REQ-009 SHALL have port lz_blank  input  1  leading-zero blanking enable.
REQ-010 SHALL have port wr_ack  output  1  one-cycle write-accepted pulse.
REQ-011 SHALL have port control  output  4  active-low one-hot digit enables.
REQ-012 SHALL have port display  output  8  active-low segments {dp,g,f,e,d,c,b,a}.
REQ-013 SHALL have port digit_idx  output  2  index of the digit currently shown.

Function
REQ-014 SHALL implement FSM states IDLE, SHOW, GAP; all outputs registered.
REQ-015 IDLE: control=4'b1111, display=8'hFF; enable=1 -> SHOW with digit_idx=0, dwell counter cleared.
REQ-016 SHOW: control bit digit_idx low, all others high; display = encoding of the committed digit; after DIV cycles -> GAP.
REQ-017 GAP: control=4'b1111, display=8'hFF for BLANK cycles; then digit_idx increments with wrap 3->0 and -> SHOW.
REQ-018 enable=0 in any state SHALL force IDLE on the next edge; digit_idx resets to 0.
REQ-019 Writes SHALL go to a 4x5 shadow buffer; wr_en samples wr_addr/wr_data every cycle; wr_ack=1 the following cycle only.
REQ-020 Shadow SHALL copy to the committed buffer on the GAP->SHOW edge where digit_idx wraps 3->0 (frame boundary), and every cycle while in IDLE.
REQ-021 A write in the same cycle as a commit SHALL land in shadow and appear at the next commit; no frame shows a mixed old/new digit set.
REQ-022 Hex encoding (dp off): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E; dp=1 clears bit7.
REQ-023 With lz_blank=1: digit3 blank if its value is 0; digit2 blank if digits 3 and 2 are 0; digit1 blank if digits 3..1 are 0; digit0 never blank; blanked digit display=8'hFF incl. dp; control still asserts.
REQ-024 Dwell counter width SHALL be 16 bits, gap counter 8 bits; neither overflows within legal parameter ranges.

Reset
REQ-025 reset low SHALL immediately (asynchronously) force IDLE, control=4'b1111, display=8'hFF, digit_idx=0, wr_ack=0, both buffers=5'b00000.
REQ-026 Reset release SHALL take effect on the next clk edge; a write pending at assertion is discarded without wr_ack.

Verification (DIV=4, BLANK=1)
REQ-027 Reset, enable=1, no writes -> control cycles 1110,1111,1101,1111,1011,1111,0111,1111; display=C0 in each SHOW, FF in each GAP; SHOW lasts 4 clocks, GAP 1.
REQ-028 In IDLE write addr0=5'h17, addr1=5'h02 -> wr_ack pulses once per write; after enable, digit0 shows 78 (7+dp), digit1 shows A4.
REQ-029 During digit1 SHOW write addr0=5'h05 -> digit0 keeps old value for the rest of the frame; first SHOW after wrap shows 92.
REQ-030 lz_blank=1, digits {3..0}={0,0,4,0} -> digits3,2 display FF, digit1 99, digit0 C0.
REQ-031 enable dropped mid-SHOW of digit2 -> next edge control=1111, display=FF, digit_idx=0; re-enable restarts at digit0.
REQ-032 reset asserted between clk edges during SHOW -> outputs go to reset values without waiting for clk; buffers read 0 after re-enable.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with a shadow/committed digit buffer,
// frame-synchronous commit and optional leading-zero blanking. All outputs are registered.
module seg_scan_ctrl #(
    parameter int DIV   = 1000,
    parameter int BLANK = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [4:0] wr_data,
    input  logic       lz_blank,
    output logic       wr_ack,
    output logic [3:0] control,
    output logic [7:0] display,
    output logic [1:0] digit_idx
);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } state_t;

    localparam logic [15:0] DWELL_LAST = 16'(DIV - 1);
    localparam logic [7:0]  GAP_LAST   = 8'(BLANK - 1);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  idx_nxt;
    logic [15:0] dwell;
    logic [15:0] dwell_nxt;
    logic [7:0]  gap;
    logic [7:0]  gap_nxt;
    logic        commit;
    logic [4:0]  shadow [4];
    logic [4:0]  committed [4];
    logic [4:0]  committed_nxt [4];
    logic [3:0]  blank;
    logic [3:0]  control_nxt;
    logic [7:0]  display_nxt;
    logic [4:0]  sel;
    logic [7:0]  enc;

    function automatic logic [7:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0:    hex_seg = 8'hC0;
            4'h1:    hex_seg = 8'hF9;
            4'h2:    hex_seg = 8'hA4;
            4'h3:    hex_seg = 8'hB0;
            4'h4:    hex_seg = 8'h99;
            4'h5:    hex_seg = 8'h92;
            4'h6:    hex_seg = 8'h82;
            4'h7:    hex_seg = 8'hF8;
            4'h8:    hex_seg = 8'h80;
            4'h9:    hex_seg = 8'h90;
            4'hA:    hex_seg = 8'h88;
            4'hB:    hex_seg = 8'h83;
            4'hC:    hex_seg = 8'hC6;
            4'hD:    hex_seg = 8'hA1;
            4'hE:    hex_seg = 8'h86;
            default: hex_seg = 8'h8E;
        endcase
    endfunction

    // Outputs are computed from the next-state values so they change on the same edge as the FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            digit_idx <= 2'd0;
            dwell     <= 16'd0;
            gap       <= 8'd0;
            control   <= 4'hF;
            display   <= 8'hFF;
        end else begin
            state     <= state_nxt;
            digit_idx <= idx_nxt;
            dwell     <= dwell_nxt;
            gap       <= gap_nxt;
            control   <= control_nxt;
            display   <= display_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ack <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow[i]    <= 5'b00000;
                committed[i] <= 5'b00000;
            end
        end else begin
            wr_ack <= wr_en;
            if (wr_en) begin
                shadow[wr_addr] <= wr_data;
            end
            for (int i = 0; i < 4; i++) begin
                committed[i] <= committed_nxt[i];
            end
        end
    end

    // Commit copies the pre-write shadow, so a write on a commit edge waits for the next frame.
    always_comb begin
        state_nxt = state;
        idx_nxt   = digit_idx;
        dwell_nxt = dwell;
        gap_nxt   = gap;
        commit    = 1'b0;
        unique case (state)
            IDLE: begin
                commit = 1'b1;
                if (enable) begin
                    state_nxt = SHOW;
                    idx_nxt   = 2'd0;
                    dwell_nxt = 16'd0;
                end
            end
            SHOW: begin
                if (dwell == DWELL_LAST) begin
                    state_nxt = GAP;
                    gap_nxt   = 8'd0;
                end else begin
                    dwell_nxt = dwell + 16'd1;
                end
            end
            GAP: begin
                if (gap == GAP_LAST) begin
                    state_nxt = SHOW;
                    idx_nxt   = digit_idx + 2'd1;
                    dwell_nxt = 16'd0;
                    commit    = (digit_idx == 2'd3);
                end else begin
                    gap_nxt = gap + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!enable) begin
            state_nxt = IDLE;
            idx_nxt   = 2'd0;
            dwell_nxt = 16'd0;
            gap_nxt   = 8'd0;
            commit    = (state == IDLE);
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            committed_nxt[i] = commit ? shadow[i] : committed[i];
        end
    end

    assign blank[0] = 1'b0;
    assign blank[3] = lz_blank && (committed_nxt[3][3:0] == 4'h0);
    assign blank[2] = blank[3] && (committed_nxt[2][3:0] == 4'h0);
    assign blank[1] = blank[2] && (committed_nxt[1][3:0] == 4'h0);

    always_comb begin
        control_nxt = 4'hF;
        display_nxt = 8'hFF;
        sel         = committed_nxt[idx_nxt];
        enc         = hex_seg(sel[3:0]);
        if (state_nxt == SHOW) begin
            control_nxt = ~(4'b0001 << idx_nxt);
            if (!blank[idx_nxt]) begin
                display_nxt = {enc[7] & ~sel[4], enc[6:0]};
            end
        end
    end

endmodule
